sdram_arbiter: RTL and testbench

Shares the single external SDRAM byte port between three requesters: the ioctl ROM loader, cartridge slot A and cartridge slot B. Replaces the combinational SLTSL-based SDRAM mux with a sequenced request/acknowledge front end. It guarantees one outstanding SDRAM command at a time, fair A/B access and a bounded completion time. It sits between the slot logic and the SDRAM controller and runs on every `clk` edge; it does not use `clk_en`.

---
 rtl/msx_sdram_pkg.sv | 16 +
 rtl/sdram_arbiter_if.sv | 32 +++
 rtl/sdram_rr_pick.sv | 24 ++
 rtl/sdram_arbiter.sv | 125 ++++++++++++
 tb/tb_sdram_arbiter.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/msx_sdram_pkg.sv
// Shared types and constants for the SDRAM byte-port arbiter.
package msx_sdram_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitAccept,
    StWaitDone
  } sdram_arb_state_t;

  localparam int NUM_REQ  = 3;
  localparam int REQ_LOAD = 0;
  localparam int REQ_A    = 1;
  localparam int REQ_B    = 2;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Requester and SDRAM-controller signals of the arbiter; slave = arbiter side.
interface sdram_arbiter_if #(
  parameter int unsigned AW = 25
) ();

  logic [msx_sdram_pkg::NUM_REQ-1:0]      req;
  logic [msx_sdram_pkg::NUM_REQ-1:0]      req_we;
  logic [msx_sdram_pkg::NUM_REQ*AW-1:0]   req_addr;
  logic [msx_sdram_pkg::NUM_REQ*8-1:0]    req_wdata;
  logic [msx_sdram_pkg::NUM_REQ-1:0]      ack;
  logic [7:0]                             rdata;
  logic [msx_sdram_pkg::NUM_REQ-1:0]      grant;
  logic                                   busy;
  logic                                   timeout_err;
  logic [AW-1:0]                          sdram_addr;
  logic [7:0]                             sdram_din;
  logic                                   sdram_rd;
  logic                                   sdram_we;
  logic                                   sdram_ready;
  logic [7:0]                             sdram_dout;

  modport slave (
    input  req, req_we, req_addr, req_wdata, sdram_ready, sdram_dout,
    output ack, rdata, grant, busy, timeout_err, sdram_addr, sdram_din, sdram_rd, sdram_we
  );

  modport master (
    output req, req_we, req_addr, req_wdata, sdram_ready, sdram_dout,
    input  ack, rdata, grant, busy, timeout_err, sdram_addr, sdram_din, sdram_rd, sdram_we
  );

endinterface

// File: rtl/sdram_rr_pick.sv
// Winner selection: loader has fixed priority, slots A/B alternate on a tie.
module sdram_rr_pick
  import msx_sdram_pkg::*;
(
  input  logic [NUM_REQ-1:0] elig,
  input  logic               last_slot,  // 1 = slot B was granted last
  output logic [NUM_REQ-1:0] win
);

  always_comb begin
    win = '0;
    if (elig[REQ_LOAD]) begin
      win[REQ_LOAD] = 1'b1;
    end else if (elig[REQ_A] && elig[REQ_B]) begin
      if (last_slot) win[REQ_A] = 1'b1;
      else           win[REQ_B] = 1'b1;
    end else if (elig[REQ_A]) begin
      win[REQ_A] = 1'b1;
    end else if (elig[REQ_B]) begin
      win[REQ_B] = 1'b1;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Sequenced request/acknowledge front end sharing one SDRAM byte port among
// the ROM loader and cartridge slots A/B, one command outstanding at a time.
module sdram_arbiter
  import msx_sdram_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned AW      = 25
) (
  input  logic            clk,
  input  logic            reset_n,
  sdram_arbiter_if.slave  bus
);

  sdram_arb_state_t   state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] ack_q;
  logic               last_slot_q;
  logic [7:0]         cnt_q;
  logic [7:0]         rdata_q;
  logic [7:0]         din_q;
  logic [AW-1:0]      addr_q;
  logic               rd_q;
  logic               we_q;
  logic               terr_q;

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] win;
  logic [AW-1:0]      sel_addr;
  logic [7:0]         sel_wdata;
  logic               sel_we;
  logic [8:0]         cnt_inc;
  logic               waiting;
  logic               done_ok;
  logic               timed_out;

  // A requester being acknowledged this cycle has not had a chance to drop req yet.
  assign elig = bus.req & ~ack_q;

  sdram_rr_pick u_pick (
    .elig      (elig),
    .last_slot (last_slot_q),
    .win       (win)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win[i]) begin
        sel_addr  = bus.req_addr[i*AW +: AW];
        sel_wdata = bus.req_wdata[i*8 +: 8];
        sel_we    = bus.req_we[i];
      end
    end
  end

  assign cnt_inc   = {1'b0, cnt_q} + 9'd1;
  assign waiting   = (state_q == StWaitAccept) || (state_q == StWaitDone);
  assign done_ok   = (state_q == StWaitDone) && bus.sdram_ready;
  assign timed_out = waiting && !done_ok && (cnt_inc == 9'(TIMEOUT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      ack_q       <= '0;
      last_slot_q <= 1'b1;
      cnt_q       <= '0;
      rdata_q     <= 8'hFF;
      din_q       <= '0;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      we_q        <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      ack_q <= '0;
      rd_q  <= 1'b0;
      we_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.sdram_ready && (|elig)) begin
            grant_q <= win;
            addr_q  <= sel_addr;
            din_q   <= sel_wdata;
            // Strobe registered here so it is visible for exactly the ISSUE cycle.
            rd_q    <= !sel_we;
            we_q    <= sel_we;
            cnt_q   <= '0;
            state_q <= StIssue;
            if (win[REQ_A])      last_slot_q <= 1'b0;
            else if (win[REQ_B]) last_slot_q <= 1'b1;
          end
        end
        StIssue: begin
          state_q <= StWaitAccept;
        end
        StWaitAccept, StWaitDone: begin
          cnt_q <= cnt_inc[7:0];
          if (done_ok || timed_out) begin
            ack_q   <= grant_q;
            grant_q <= '0;
            rdata_q <= done_ok ? bus.sdram_dout : 8'hFF;
            state_q <= StIdle;
            if (timed_out) terr_q <= 1'b1;
          end else if (state_q == StWaitAccept && !bus.sdram_ready) begin
            state_q <= StWaitDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ack         = ack_q;
  assign bus.rdata       = rdata_q;
  assign bus.grant       = grant_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.timeout_err = terr_q;
  assign bus.sdram_addr  = addr_q;
  assign bus.sdram_din   = din_q;
  assign bus.sdram_rd    = rd_q;
  assign bus.sdram_we    = we_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: directed transactions against a simple
// SDRAM controller model; a monitor checks every ack against queued expectations.
module tb_sdram_arbiter;

  typedef struct {
    logic [2:0] ack;
    logic [7:0] rdata;
    bit         chk_rd;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;

  sdram_arbiter_if #(.AW(25)) bus ();

  sdram_arbiter #(
    .TIMEOUT (255),
    .AW      (25)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  int   strobe_cnt = 0;
  exp_t exp_q[$];

  // Controller model knobs
  bit       m_nodrop = 1'b0;
  int       m_low = 1;
  logic [7:0] m_dout = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [2:0] a, input logic [7:0] d, input bit c);
    exp_t e;
    e.ack = a; e.rdata = d; e.chk_rd = c;
    exp_q.push_back(e);
  endtask

  task automatic set_req(input int i, input bit we, input logic [24:0] addr,
                         input logic [7:0] wd);
    bus.req_we[i]             = we;
    bus.req_addr[i*25 +: 25]  = addr;
    bus.req_wdata[i*8 +: 8]   = wd;
    bus.req[i]                = 1'b1;
  endtask

  task automatic wait_acks(input int n, input bit drop, input int budget);
    int got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      @(negedge clk);
      if (bus.ack != 3'b000) begin
        got++;
        if (drop) bus.req = bus.req & ~bus.ack;
      end
    end
    check("ack_count", got, n);
  endtask

  // SDRAM controller model: drops ready the cycle after the strobe, raises it m_low cycles later.
  initial begin
    bus.sdram_ready = 1'b1;
    bus.sdram_dout  = 8'h00;
    forever begin
      @(negedge clk);
      if ((bus.sdram_rd || bus.sdram_we) && !m_nodrop) begin
        @(posedge clk);
        #1 bus.sdram_ready = 1'b0;
        repeat (m_low) @(posedge clk);
        #1;
        bus.sdram_ready = 1'b1;
        bus.sdram_dout  = m_dout;
      end
    end
  end

  // Monitor: pops the scoreboard on every ack, checks no re-grant in the following cycle.
  initial begin
    logic [2:0] prev_ack = 3'b000;
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.sdram_rd || bus.sdram_we) strobe_cnt++;
      if (prev_ack != 3'b000) check("no_regrant", {29'd0, bus.grant & prev_ack}, 32'd0);
      if (bus.ack != 3'b000) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_ack: got %b expected none at %0t", bus.ack, $time);
        end else begin
          e = exp_q.pop_front();
          check("sb_ack", {29'd0, bus.ack}, {29'd0, e.ack});
          if (e.chk_rd) check("sb_rdata", {24'd0, bus.rdata}, {24'd0, e.rdata});
        end
      end
      prev_ack = bus.ack;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ns, na, c, s0;

    reset_n       = 1'b0;
    bus.req       = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (3) @(negedge clk);

    check("rst_ack",   {29'd0, bus.ack}, 32'd0);
    check("rst_grant", {29'd0, bus.grant}, 32'd0);
    check("rst_flags", {28'd0, bus.busy, bus.timeout_err, bus.sdram_rd, bus.sdram_we}, 32'd0);
    check("rst_rdata", {24'd0, bus.rdata}, 32'hFF);
    check("rst_addr",  {7'd0, bus.sdram_addr}, 32'd0);
    check("rst_din",   {24'd0, bus.sdram_din}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // A and B continuously requesting: A, B, A, B
    m_low = 1; m_dout = 8'h5A;
    for (int i = 0; i < 4; i++) push((i % 2 == 0) ? 3'b010 : 3'b100, 8'h5A, 1'b1);
    set_req(1, 1'b0, 25'h0000100, 8'h00);
    set_req(2, 1'b0, 25'h0000200, 8'h00);
    ns = 0; na = 0;
    for (int k = 0; k < 200 && na < 4; k++) begin
      @(negedge clk);
      if (bus.sdram_rd || bus.sdram_we) begin
        ns++;
        check("alt_addr", {7'd0, bus.sdram_addr}, (ns % 2 == 1) ? 32'h100 : 32'h200);
        if (ns == 4) bus.req[2:1] = 2'b00;
      end
      if (bus.ack != 3'b000) na++;
    end
    check("alt_acks", na, 4);
    repeat (2) @(negedge clk);

    // Slot A read 0x0012345: strobe at 1, ready low 2..4, high at 5, ack at 6
    m_low = 3; m_dout = 8'hA5;
    push(3'b010, 8'hA5, 1'b1);
    set_req(1, 1'b0, 25'h0012345, 8'h00);
    @(negedge clk);
    check("t1_rd",    {30'd0, bus.sdram_rd, bus.sdram_we}, 32'b10);
    check("t1_addr",  {7'd0, bus.sdram_addr}, 32'h0012345);
    check("t1_grant", {29'd0, bus.grant}, 32'b010);
    check("t1_busy",  {31'd0, bus.busy}, 32'd1);
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      check("t1_quiet", {27'd0, bus.sdram_rd, bus.sdram_we, bus.ack}, 32'd0);
    end
    @(negedge clk);
    check("t1_ack",   {29'd0, bus.ack}, 32'b010);
    check("t1_rdata", {24'd0, bus.rdata}, 32'hA5);
    bus.req[1] = 1'b0;
    @(negedge clk);
    check("t1_idle",  {31'd0, bus.busy}, 32'd0);

    // Loader write with A and B pending; last grant was A so B follows the loader
    m_low = 2; m_dout = 8'h66;
    push(3'b001, 8'h66, 1'b0);
    push(3'b100, 8'h66, 1'b1);
    push(3'b010, 8'h66, 1'b1);
    set_req(0, 1'b1, 25'h1000000, 8'h3C);
    set_req(1, 1'b0, 25'h0000111, 8'h00);
    set_req(2, 1'b0, 25'h0000222, 8'h00);
    @(negedge clk);
    check("ld_we",    {30'd0, bus.sdram_rd, bus.sdram_we}, 32'b01);
    check("ld_din",   {24'd0, bus.sdram_din}, 32'h3C);
    check("ld_addr",  {7'd0, bus.sdram_addr}, 32'h1000000);
    check("ld_grant", {29'd0, bus.grant}, 32'b001);
    wait_acks(3, 1'b1, 100);
    repeat (2) @(negedge clk);

    // Slot B read, ready never drops: forced completion 255 cycles after WAIT_ACCEPT entry
    m_nodrop = 1'b1;
    push(3'b100, 8'hFF, 1'b1);
    set_req(2, 1'b0, 25'h0000333, 8'h00);
    c = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      c++;
      if (bus.ack != 3'b000) break;
    end
    check("to_cycle", c, 257);
    check("to_err",   {31'd0, bus.timeout_err}, 32'd1);
    bus.req[2] = 1'b0;
    m_nodrop = 1'b0;
    @(negedge clk);
    m_low = 1; m_dout = 8'h3E;
    push(3'b010, 8'h3E, 1'b1);
    set_req(1, 1'b0, 25'h0000334, 8'h00);
    wait_acks(1, 1'b1, 50);
    check("to_sticky", {31'd0, bus.timeout_err}, 32'd1);
    @(negedge clk);

    // Reset during WAIT_DONE: no ack, reset values at once
    m_low = 20; m_dout = 8'h77;
    set_req(1, 1'b0, 25'h0000444, 8'h00);
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    bus.req = '0;
    #1;
    check("rr_ctl",   {25'd0, bus.ack, bus.grant, bus.busy}, 32'd0);
    check("rr_flags", {29'd0, bus.timeout_err, bus.sdram_rd, bus.sdram_we}, 32'd0);
    check("rr_rdata", {24'd0, bus.rdata}, 32'hFF);
    check("rr_addr",  {7'd0, bus.sdram_addr}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    m_low = 1; m_dout = 8'h88;
    set_req(2, 1'b0, 25'h0000555, 8'h00);
    repeat (3) @(negedge clk);
    // Controller still busy with the abandoned command: no grant may be made yet
    check("rr_hold", {28'd0, bus.grant, bus.busy}, 32'd0);
    push(3'b100, 8'h88, 1'b1);
    wait_acks(1, 1'b1, 100);
    @(negedge clk);

    // Slot A drops req right after grant: still completes, single strobe
    m_low = 2; m_dout = 8'h99;
    s0 = strobe_cnt;
    push(3'b010, 8'h99, 1'b1);
    set_req(1, 1'b0, 25'h0000666, 8'h00);
    @(negedge clk);
    bus.req[1] = 1'b0;
    wait_acks(1, 1'b0, 50);
    repeat (5) @(negedge clk);
    check("drop_strobes", strobe_cnt - s0, 1);
    check("sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
